// File: rtl/mips_pipeline_top.sv
// mips_pipeline_top: 5-stage (IF/ID/EX/MEM/WB) MIPS-subset core with instruction ROM, data RAM and board I/O.
// No forwarding or interlocks: software spaces dependent instructions and fills the single branch delay slot.
module mips_pipeline_top #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] IMEM_INIT [IMEM_WORDS] = '{default: 32'h0}
) (
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic [17:0] SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [8:0]  LEDG,
    output logic [17:0] LEDR
);
    localparam int          IA_W    = $clog2(IMEM_WORDS);
    localparam int          DA_W    = $clog2(DMEM_WORDS);
    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    function automatic logic signed [31:0] alu_calc(input alu_op_t op,
                                                    input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        case (op)
            ALU_SUB: alu_calc = a - b;
            ALU_AND: alu_calc = a & b;
            ALU_OR:  alu_calc = a | b;
            ALU_SLT: alu_calc = (a < b) ? 32'sd1 : 32'sd0;
            default: alu_calc = a + b;
        endcase
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [31:0] pc_p0;
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];

    logic               vld_p1;
    logic [31:0]        instr_p1, pc4_p1;
    logic               vld_p2, reg_write_p2, mem_read_p2, mem_write_p2, alu_imm_p2;
    alu_op_t            alu_op_p2;
    logic [4:0]         rd_p2;
    logic signed [31:0] rs_val_p2, rt_val_p2, imm_p2;
    logic               vld_p3, reg_write_p3, mem_read_p3, mem_write_p3;
    logic [4:0]         rd_p3;
    logic signed [31:0] alu_res_p3;
    logic [31:0]        st_data_p3;
    logic               vld_p4, reg_write_p4;
    logic [4:0]         rd_p4;
    logic [31:0]        wb_data_p4;

    // ---- IF: fetch and next-PC selection ----
    logic [31:0] instr_if, pc4_if, pc_next, br_target, j_target;
    logic        take_branch, take_jump;

    assign instr_if = IMEM_INIT[pc_p0[IA_W+1:2]];
    assign pc4_if   = pc_p0 + 32'd4;
    assign pc_next  = take_branch ? br_target : (take_jump ? j_target : pc4_if);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            pc_p0    <= '0;
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
            pc4_p1   <= '0;
        end else begin
            pc_p0    <= pc_next & PC_MASK;
            vld_p1   <= 1'b1;
            instr_p1 <= instr_if;
            pc4_p1   <= pc4_if;
        end
    end

    // ---- ID: decode, register read with WB bypass, branch resolution ----
    logic [5:0]         opcode, funct;
    logic [4:0]         rs, rt;
    logic signed [31:0] imm_sext, rs_val, rt_val;
    logic               wb_we, dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_imm;
    alu_op_t            dec_alu_op;
    logic [4:0]         dec_rd;

    assign opcode    = instr_p1[31:26];
    assign funct     = instr_p1[5:0];
    assign rs        = instr_p1[25:21];
    assign rt        = instr_p1[20:16];
    assign imm_sext  = {{16{instr_p1[15]}}, instr_p1[15:0]};
    assign wb_we     = vld_p4 && reg_write_p4 && (rd_p4 != 5'd0);
    assign rs_val    = (wb_we && rd_p4 == rs) ? wb_data_p4 : regs[rs];
    assign rt_val    = (wb_we && rd_p4 == rt) ? wb_data_p4 : regs[rt];
    assign br_target = pc4_p1 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc4_p1[31:28], instr_p1[25:0], 2'b00};

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_imm   = 1'b0;
        dec_alu_op    = ALU_ADD;
        dec_rd        = rt;
        take_branch   = 1'b0;
        take_jump     = 1'b0;
        if (vld_p1) begin
            case (opcode)
                OP_RTYPE: begin
                    dec_rd        = instr_p1[15:11];
                    dec_reg_write = 1'b1;
                    case (funct)
                        FN_ADD:  dec_alu_op = ALU_ADD;
                        FN_SUB:  dec_alu_op = ALU_SUB;
                        FN_AND:  dec_alu_op = ALU_AND;
                        FN_OR:   dec_alu_op = ALU_OR;
                        FN_SLT:  dec_alu_op = ALU_SLT;
                        default: dec_reg_write = 1'b0;
                    endcase
                end
                OP_ADDI: begin
                    dec_reg_write = 1'b1;
                    dec_alu_imm   = 1'b1;
                end
                OP_LW: begin
                    dec_reg_write = 1'b1;
                    dec_mem_read  = 1'b1;
                    dec_alu_imm   = 1'b1;
                end
                OP_SW: begin
                    dec_mem_write = 1'b1;
                    dec_alu_imm   = 1'b1;
                end
                OP_BEQ:  take_branch = (rs_val == rt_val);
                OP_BNE:  take_branch = (rs_val != rt_val);
                OP_J:    take_jump   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            vld_p2       <= 1'b0;
            reg_write_p2 <= 1'b0;
            mem_read_p2  <= 1'b0;
            mem_write_p2 <= 1'b0;
            alu_imm_p2   <= 1'b0;
            alu_op_p2    <= ALU_ADD;
            rd_p2        <= '0;
            rs_val_p2    <= '0;
            rt_val_p2    <= '0;
            imm_p2       <= '0;
        end else begin
            vld_p2       <= vld_p1;
            reg_write_p2 <= dec_reg_write;
            mem_read_p2  <= dec_mem_read;
            mem_write_p2 <= dec_mem_write;
            alu_imm_p2   <= dec_alu_imm;
            alu_op_p2    <= dec_alu_op;
            rd_p2        <= dec_rd;
            rs_val_p2    <= rs_val;
            rt_val_p2    <= rt_val;
            imm_p2       <= imm_sext;
        end
    end

    // ---- EX: ALU ----
    logic signed [31:0] alu_b, alu_res;

    assign alu_b   = alu_imm_p2 ? imm_p2 : rt_val_p2;
    assign alu_res = alu_calc(alu_op_p2, rs_val_p2, alu_b);

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            vld_p3       <= 1'b0;
            reg_write_p3 <= 1'b0;
            mem_read_p3  <= 1'b0;
            mem_write_p3 <= 1'b0;
            rd_p3        <= '0;
            alu_res_p3   <= '0;
            st_data_p3   <= '0;
        end else begin
            vld_p3       <= vld_p2;
            reg_write_p3 <= reg_write_p2;
            mem_read_p3  <= mem_read_p2;
            mem_write_p3 <= mem_write_p2;
            rd_p3        <= rd_p2;
            alu_res_p3   <= alu_res;
            st_data_p3   <= rt_val_p2;
        end
    end

    // ---- MEM: data RAM, synchronous write and combinational read ----
    logic [DA_W-1:0] dmem_idx;
    logic [31:0]     mem_rdata;

    assign dmem_idx  = alu_res_p3[DA_W+1:2];
    assign mem_rdata = dmem[dmem_idx];

    always_ff @(posedge CLOCK_50) begin
        if (vld_p3 && mem_write_p3)
            dmem[dmem_idx] <= st_data_p3;
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            vld_p4       <= 1'b0;
            reg_write_p4 <= 1'b0;
            rd_p4        <= '0;
            wb_data_p4   <= '0;
        end else begin
            vld_p4       <= vld_p3;
            reg_write_p4 <= reg_write_p3;
            rd_p4        <= rd_p3;
            wb_data_p4   <= mem_read_p3 ? mem_rdata : alu_res_p3;
        end
    end

    // ---- WB: register file write; r0 is never written so it stays zero ----
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[rd_p4] <= wb_data_p4;
        end
    end

    logic [31:0] rsel;
    logic        unused_bits;

    assign rsel        = regs[SW[4:0]];
    assign unused_bits = ^{SW[17:5], instr_p1[10:6], rsel[31:16]};

    assign HEX0 = seg7(rsel[3:0]);
    assign HEX1 = seg7(rsel[7:4]);
    assign HEX2 = seg7(rsel[11:8]);
    assign HEX3 = seg7(rsel[15:12]);
    assign HEX4 = seg7(pc_p0[3:0]);
    assign HEX5 = seg7(pc_p0[7:4]);
    assign HEX6 = seg7(pc_p0[11:8]);
    assign HEX7 = seg7(pc_p0[15:12]);
    assign LEDG = {7'b0, vld_p3 & mem_write_p3, vld_p4 & reg_write_p4};
    assign LEDR = pc_p0[17:0];

endmodule

// File: tb/tb_mips_pipeline_top.sv
// Bench for mips_pipeline_top: runs a directed program from ROM and scoreboards PC, LEDs and register display.
module tb_mips_pipeline_top;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam int         NCYC    = 70;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {OP_J, tgt};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [31:0] seg16(input logic [15:0] v);
        return {4'h0, seg7(v[15:12]), seg7(v[11:8]), seg7(v[7:4]), seg7(v[3:0])};
    endfunction

    localparam logic [31:0] PROG [256] = '{
        0:  enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5),
        3:  enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7),
        6:  enc_r(5'd1, 5'd2, 5'd3, FN_ADD),
        7:  enc_r(5'd1, 5'd2, 5'd4, FN_SUB),
        10: enc_r(5'd4, 5'd1, 5'd5, FN_SLT),
        11: enc_r(5'd1, 5'd2, 5'd12, FN_AND),
        12: enc_r(5'd1, 5'd2, 5'd13, FN_OR),
        13: enc_i(OP_SW, 5'd0, 5'd3, 16'd8),
        16: enc_i(OP_LW, 5'd0, 5'd6, 16'd8),
        19: enc_i(OP_SW, 5'd0, 5'd1, 16'd12),
        20: enc_i(OP_LW, 5'd0, 5'd14, 16'd12),
        21: enc_i(OP_LW, 5'd0, 5'd15, 16'd264),
        22: enc_i(OP_ADDI, 5'd0, 5'd7, 16'd9),
        23: enc_r(5'd7, 5'd0, 5'd8, FN_ADD),
        24: enc_r(5'd7, 5'd0, 5'd16, FN_ADD),
        25: enc_r(5'd7, 5'd0, 5'd17, FN_ADD),
        26: enc_i(OP_BEQ, 5'd1, 5'd1, 16'd2),
        27: enc_i(OP_ADDI, 5'd0, 5'd9, 16'd1),
        28: enc_i(OP_ADDI, 5'd0, 5'd10, 16'd1),
        29: enc_i(OP_BNE, 5'd1, 5'd1, 16'd2),
        30: enc_i(OP_ADDI, 5'd0, 5'd18, 16'd3),
        31: enc_i(OP_ADDI, 5'd0, 5'd19, 16'd4),
        32: enc_i(OP_BNE, 5'd1, 5'd2, 16'd2),
        33: enc_i(OP_ADDI, 5'd0, 5'd20, 16'd2),
        34: enc_i(OP_ADDI, 5'd0, 5'd21, 16'd5),
        35: enc_i(OP_ADDI, 5'd0, 5'd22, 16'hFFFF),
        36: enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7),
        37: enc_j(26'd40),
        39: enc_i(OP_ADDI, 5'd0, 5'd23, 16'd1),
        40: enc_j(26'd40),
        default: 32'h0
    };

    logic        CLOCK_50 = 1'b0;
    logic        RST_N    = 1'b1;
    logic [17:0] SW       = '0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [8:0]  LEDG;
    logic [17:0] LEDR;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    int          trace[$];
    bit          wr_word[64];
    bit          st_word[64];
    int          wr_list[$] = '{0, 3, 6, 7, 10, 11, 12, 16, 20, 21, 22, 23, 24, 25, 27, 30, 31, 33, 35, 36};
    logic [31:0] exp_reg[32] = '{
        32'h0, 32'd5, 32'd7, 32'd12, 32'hFFFF_FFFE, 32'd1, 32'd12, 32'd9,
        32'h0, 32'd1, 32'h0, 32'h0, 32'd5, 32'd7, 32'd5, 32'd12,
        32'h0, 32'd9, 32'd3, 32'd4, 32'd2, 32'h0, 32'hFFFF_FFFF, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
    };

    mips_pipeline_top #(
        .IMEM_WORDS(256),
        .DMEM_WORDS(64),
        .IMEM_INIT (PROG)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RST_N   (RST_N),
        .SW      (SW),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .HEX4    (HEX4),
        .HEX5    (HEX5),
        .HEX6    (HEX6),
        .HEX7    (HEX7),
        .LEDG    (LEDG),
        .LEDR    (LEDR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic check_regs(input string pfx, input bit all_zero);
        for (int r = 0; r < 32; r++) begin
            SW = {13'h1ABC, 5'(r)};
            expect_val($sformatf("%s_r%0d", pfx, r), seg16(all_zero ? 16'h0 : exp_reg[r][15:0]));
            #1;
            pop_check({4'h0, HEX3, HEX2, HEX1, HEX0});
        end
    endtask

    initial begin
        logic [31:0] e_ledg;

        foreach (wr_list[i]) wr_word[wr_list[i]] = 1'b1;
        st_word[13] = 1'b1;
        st_word[19] = 1'b1;
        for (int w = 0; w <= 27; w++) trace.push_back(w);
        for (int w = 29; w <= 33; w++) trace.push_back(w);
        for (int w = 35; w <= 38; w++) trace.push_back(w);
        while (trace.size() < NCYC) begin
            trace.push_back(40);
            trace.push_back(41);
        end

        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        expect_val("reset_ledr", 32'h0);
        expect_val("reset_ledg", 32'h0);
        #1;
        pop_check({14'h0, LEDR});
        pop_check({23'h0, LEDG});
        check_regs("reset", 1'b1);

        // release reset and follow the program one cycle at a time
        @(negedge CLOCK_50);
        RST_N = 1'b1;
        for (int k = 0; k < NCYC; k++) begin
            e_ledg = '0;
            if (k >= 3 && st_word[trace[k-3]]) e_ledg[1] = 1'b1;
            if (k >= 4 && wr_word[trace[k-4]]) e_ledg[0] = 1'b1;
            expect_val($sformatf("ledr_c%0d", k), 32'(trace[k] * 4));
            expect_val($sformatf("ledg_c%0d", k), e_ledg);
            expect_val($sformatf("hexpc_c%0d", k), seg16(16'(trace[k] * 4)));
            #1;
            pop_check({14'h0, LEDR});
            pop_check({23'h0, LEDG});
            pop_check({4'h0, HEX7, HEX6, HEX5, HEX4});
            @(negedge CLOCK_50);
        end

        check_regs("final", 1'b0);

        // asynchronous reset while spinning in the jump loop
        @(posedge CLOCK_50);
        #2;
        RST_N = 1'b0;
        expect_val("midrst_ledr", 32'h0);
        expect_val("midrst_ledg", 32'h0);
        expect_val("midrst_hexpc", seg16(16'h0));
        #1;
        pop_check({14'h0, LEDR});
        pop_check({23'h0, LEDG});
        pop_check({4'h0, HEX7, HEX6, HEX5, HEX4});
        check_regs("midrst", 1'b1);

        @(negedge CLOCK_50);
        RST_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_val($sformatf("restart_ledr_c%0d", k), 32'(k * 4));
            #1;
            pop_check({14'h0, LEDR});
            @(negedge CLOCK_50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
